// File: rtl/reorder_buffer_mc.sv
// Multi-commit reorder buffer: in-order retirement of up to COMMIT_WIDTH register writes per
// cycle, store handshake to the LSB and a registered flush on branch mispredict.
module reorder_buffer_mc #(
   parameter int unsigned ROB_BITS     = 3,
   parameter int unsigned COMMIT_WIDTH = 2,
   parameter int unsigned TYPE_BITS    = 2
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic                             i_rdy,
   input  logic                             i_alloc_valid,
   input  logic [TYPE_BITS-1:0]             i_alloc_type,
   input  logic [4:0]                       i_alloc_rd,
   input  logic [31:0]                      i_alloc_value,
   input  logic [31:0]                      i_alloc_pc,
   input  logic [31:0]                      i_alloc_jump_addr,
   input  logic                             i_alloc_ready,
   output logic                             o_full,
   output logic                             o_empty,
   output logic [ROB_BITS:0]                o_count,
   output logic [ROB_BITS-1:0]              o_head,
   output logic [ROB_BITS-1:0]              o_tail,
   input  logic                             i_wb0_valid,
   input  logic [ROB_BITS-1:0]              i_wb0_id,
   input  logic [31:0]                      i_wb0_value,
   input  logic                             i_wb1_valid,
   input  logic [ROB_BITS-1:0]              i_wb1_id,
   input  logic [31:0]                      i_wb1_value,
   output logic [COMMIT_WIDTH-1:0]          o_commit_valid,
   output logic [5*COMMIT_WIDTH-1:0]        o_commit_rd,
   output logic [32*COMMIT_WIDTH-1:0]       o_commit_value,
   output logic [ROB_BITS*COMMIT_WIDTH-1:0] o_commit_id,
   output logic                             o_set_dep_valid,
   output logic [4:0]                       o_set_dep_rd,
   output logic [ROB_BITS-1:0]              o_set_dep_id,
   output logic                             o_store_commit,
   output logic [ROB_BITS-1:0]              o_store_commit_id,
   input  logic [ROB_BITS-1:0]              i_query_id0,
   input  logic [ROB_BITS-1:0]              i_query_id1,
   output logic                             o_query_ready0,
   output logic                             o_query_ready1,
   output logic [31:0]                      o_query_value0,
   output logic [31:0]                      o_query_value1,
   output logic                             o_clear,
   output logic [31:0]                      o_next_pc
);

   localparam int unsigned DEPTH = 1 << ROB_BITS;
   localparam logic [TYPE_BITS-1:0] TypeR = TYPE_BITS'(0);
   localparam logic [TYPE_BITS-1:0] TypeB = TYPE_BITS'(1);
   localparam logic [TYPE_BITS-1:0] TypeS = TYPE_BITS'(2);

   logic                 r_busy  [DEPTH];
   logic                 r_ready [DEPTH];
   logic [TYPE_BITS-1:0] r_type  [DEPTH];
   logic [4:0]           r_rd    [DEPTH];
   logic [31:0]          r_value [DEPTH];
   logic [31:0]          r_pc    [DEPTH];
   logic [31:0]          r_jump  [DEPTH];
   logic [ROB_BITS-1:0]  r_head, r_tail;
   logic [ROB_BITS:0]    r_count;
   logic                 r_clear;
   logic [31:0]          r_next_pc;

   logic                w_live, w_full, w_alloc, w_mispredict, w_unused_pc;
   logic [ROB_BITS-1:0] w_head1;
   logic [1:0]          w_fire;
   logic [ROB_BITS-1:0] w_idx [2];
   logic [ROB_BITS:0]   w_ncommit;
   logic [ROB_BITS-1:0] w_qid [2];
   logic                w_qrdy [2];
   logic [31:0]         w_qval [2];

   always_comb begin
      w_full  = (r_count == (ROB_BITS+1)'(DEPTH));
      // Nothing allocates, writes back or retires while a flush is pending.
      w_live  = i_rdy && !r_clear;
      w_alloc = w_live && i_alloc_valid && !w_full;
      w_head1 = r_head + ROB_BITS'(1);
      w_idx[0] = r_head;
      w_idx[1] = w_head1;
      w_fire[0] = w_live && r_busy[r_head] && r_ready[r_head];
      w_fire[1] = (COMMIT_WIDTH == 2) && w_fire[0] && r_busy[w_head1] && r_ready[w_head1] &&
                  (r_type[r_head] == TypeR) && (r_type[w_head1] == TypeR);
      w_ncommit = (ROB_BITS+1)'(w_fire[0]) + (ROB_BITS+1)'(w_fire[1]);
      w_mispredict = w_fire[0] && (r_type[r_head] == TypeB) && !r_value[r_head][0];

      o_commit_valid = '0;
      o_commit_rd    = '0;
      o_commit_value = '0;
      o_commit_id    = '0;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         if (w_fire[k] && (r_type[w_idx[k]] == TypeR) && (r_rd[w_idx[k]] != 5'd0)) begin
            o_commit_valid[k]                    = 1'b1;
            o_commit_rd[5*k +: 5]                = r_rd[w_idx[k]];
            o_commit_value[32*k +: 32]           = r_value[w_idx[k]];
            o_commit_id[ROB_BITS*k +: ROB_BITS]  = w_idx[k];
         end
      end

      o_store_commit    = w_fire[0] && (r_type[r_head] == TypeS);
      o_store_commit_id = o_store_commit ? r_head : '0;

      o_set_dep_valid = w_alloc && (i_alloc_type == TypeR) && (i_alloc_rd != 5'd0);
      o_set_dep_rd    = o_set_dep_valid ? i_alloc_rd : '0;
      o_set_dep_id    = o_set_dep_valid ? r_tail : '0;

      // Forwarding priority: stored result, then wb1, wb0, and finally the entry being allocated.
      w_qid[0] = i_query_id0;
      w_qid[1] = i_query_id1;
      for (int n = 0; n < 2; n++) begin
         w_qrdy[n] = 1'b0;
         w_qval[n] = '0;
         if (i_rdy) begin
            if (r_ready[w_qid[n]]) begin
               w_qrdy[n] = 1'b1;
               w_qval[n] = r_value[w_qid[n]];
            end else if (i_wb1_valid && (i_wb1_id == w_qid[n])) begin
               w_qrdy[n] = 1'b1;
               w_qval[n] = i_wb1_value;
            end else if (i_wb0_valid && (i_wb0_id == w_qid[n])) begin
               w_qrdy[n] = 1'b1;
               w_qval[n] = i_wb0_value;
            end else if (w_alloc && i_alloc_ready && (r_tail == w_qid[n])) begin
               w_qrdy[n] = 1'b1;
               w_qval[n] = i_alloc_value;
            end
         end
      end

      w_unused_pc = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         w_unused_pc = w_unused_pc ^ (^r_pc[i]);
      end
   end

   assign o_query_ready0 = w_qrdy[0];
   assign o_query_ready1 = w_qrdy[1];
   assign o_query_value0 = w_qval[0];
   assign o_query_value1 = w_qval[1];
   assign o_full  = w_full;
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_head;
   assign o_tail  = r_tail;
   assign o_clear = r_clear;
   assign o_next_pc = r_next_pc;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_clear   <= 1'b0;
         r_next_pc <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_busy[i]  <= 1'b0;
            r_ready[i] <= 1'b0;
         end
      end else if (i_rdy) begin
         if (r_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_clear <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
               r_busy[i]  <= 1'b0;
               r_ready[i] <= 1'b0;
            end
         end else begin
            // wb1 is written last so it wins a same-id collision.
            if (i_wb0_valid && r_busy[i_wb0_id]) begin
               r_value[i_wb0_id] <= i_wb0_value;
               r_ready[i_wb0_id] <= 1'b1;
            end
            if (i_wb1_valid && r_busy[i_wb1_id]) begin
               r_value[i_wb1_id] <= i_wb1_value;
               r_ready[i_wb1_id] <= 1'b1;
            end
            if (w_alloc) begin
               r_busy[r_tail]  <= 1'b1;
               r_ready[r_tail] <= i_alloc_ready;
               r_type[r_tail]  <= i_alloc_type;
               r_rd[r_tail]    <= i_alloc_rd;
               r_value[r_tail] <= i_alloc_value;
               r_pc[r_tail]    <= i_alloc_pc;
               r_jump[r_tail]  <= i_alloc_jump_addr;
               r_tail          <= r_tail + ROB_BITS'(1);
            end
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
               if (w_fire[k]) begin
                  r_busy[w_idx[k]]  <= 1'b0;
                  r_ready[w_idx[k]] <= 1'b0;
               end
            end
            r_head  <= r_head + ROB_BITS'(w_ncommit);
            r_count <= r_count + (ROB_BITS+1)'(w_alloc) - w_ncommit;
            if (w_mispredict) begin
               r_clear   <= 1'b1;
               r_next_pc <= r_jump[r_head];
            end
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Randomized bench for reorder_buffer_mc against an in-order queue model of the ROB.
module tb_reorder_buffer_mc;

   localparam int D = 8;

   logic        clk = 1'b0;
   logic        rst, rdy, av, aready;
   logic [1:0]  atype;
   logic [4:0]  ard;
   logic [31:0] avalue, apc, ajump;
   logic        wb0v, wb1v;
   logic [2:0]  wb0id, wb1id, q0, q1;
   logic [31:0] wb0val, wb1val;

   logic        o_full, o_empty, o_set_dep_valid, o_store_commit;
   logic [3:0]  o_count;
   logic [2:0]  o_head, o_tail, o_set_dep_id, o_store_commit_id;
   logic [1:0]  o_commit_valid;
   logic [9:0]  o_commit_rd;
   logic [63:0] o_commit_value;
   logic [5:0]  o_commit_id;
   logic [4:0]  o_set_dep_rd;
   logic        o_query_ready0, o_query_ready1, o_clear;
   logic [31:0] o_query_value0, o_query_value1, o_next_pc;

   always #5 clk = ~clk;

   reorder_buffer_mc #(.ROB_BITS(3), .COMMIT_WIDTH(2), .TYPE_BITS(2)) dut (
      .i_clk(clk), .i_rst(rst), .i_rdy(rdy),
      .i_alloc_valid(av), .i_alloc_type(atype), .i_alloc_rd(ard), .i_alloc_value(avalue),
      .i_alloc_pc(apc), .i_alloc_jump_addr(ajump), .i_alloc_ready(aready),
      .o_full(o_full), .o_empty(o_empty), .o_count(o_count), .o_head(o_head), .o_tail(o_tail),
      .i_wb0_valid(wb0v), .i_wb0_id(wb0id), .i_wb0_value(wb0val),
      .i_wb1_valid(wb1v), .i_wb1_id(wb1id), .i_wb1_value(wb1val),
      .o_commit_valid(o_commit_valid), .o_commit_rd(o_commit_rd),
      .o_commit_value(o_commit_value), .o_commit_id(o_commit_id),
      .o_set_dep_valid(o_set_dep_valid), .o_set_dep_rd(o_set_dep_rd), .o_set_dep_id(o_set_dep_id),
      .o_store_commit(o_store_commit), .o_store_commit_id(o_store_commit_id),
      .i_query_id0(q0), .i_query_id1(q1),
      .o_query_ready0(o_query_ready0), .o_query_ready1(o_query_ready1),
      .o_query_value0(o_query_value0), .o_query_value1(o_query_value1),
      .o_clear(o_clear), .o_next_pc(o_next_pc)
   );

   typedef struct {
      int          id;
      bit          ready;
      int          typ;
      int          rd;
      logic [31:0] value;
      logic [31:0] jump;
   } ent_t;

   ent_t        rob[$];
   int          m_head, m_tail;
   bit          m_clear;
   logic [31:0] m_next_pc;
   int          n_vec, n_err;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int find_id(input int id);
      for (int k = 0; k < rob.size(); k++) if (rob[k].id == id) return k;
      return -1;
   endfunction

   function automatic void exp_query(input int q, input bit acc, output logic r,
                                     output logic [31:0] v);
      int k;
      bit st, h0, h1, ha;
      k  = find_id(q);
      st = (k >= 0) && rob[k].ready;
      h1 = wb1v && (int'(wb1id) == q);
      h0 = wb0v && (int'(wb0id) == q);
      ha = acc && aready && (m_tail == q);
      r  = rdy && (st || h0 || h1 || ha);
      if (!rdy)    v = '0;
      else if (st) v = rob[k].value;
      else if (h1) v = wb1val;
      else if (h0) v = wb0val;
      else if (ha) v = avalue;
      else         v = '0;
   endfunction

   task automatic reset_model();
      rob.delete();
      m_head = 0; m_tail = 0; m_clear = 0; m_next_pc = '0;
   endtask

   task automatic idle();
      rst = 0; rdy = 1; av = 0; aready = 0; atype = 0; ard = 0; avalue = 0; apc = 0; ajump = 0;
      wb0v = 0; wb1v = 0; wb0id = 0; wb1id = 0; wb0val = 0; wb1val = 0; q0 = 0; q1 = 0;
   endtask

   task automatic alloc(input int typ, input int rd, input bit rdyf, input logic [31:0] val,
                        input logic [31:0] jump);
      av = 1; atype = 2'(typ); ard = 5'(rd); aready = rdyf; avalue = val; ajump = jump;
      apc = $urandom;
   endtask

   // Compare every output against the model for the current inputs, then advance one clock.
   task automatic cycle();
      bit acc, c0, c1, fire, mis;
      int n, k;
      logic [1:0]  ecv;
      logic [9:0]  erd;
      logic [63:0] eval;
      logic [5:0]  eid;
      logic        qr;
      logic [31:0] qv;
      ent_t        e;
      #1;
      check_eq("count", o_count, 64'(rob.size()));
      check_eq("full", o_full, 64'(rob.size() == D));
      check_eq("empty", o_empty, 64'(rob.size() == 0));
      check_eq("head", o_head, 64'(m_head));
      check_eq("tail", o_tail, 64'(m_tail));
      check_eq("clear", o_clear, 64'(m_clear));
      check_eq("next_pc", o_next_pc, 64'(m_next_pc));
      acc = rdy && av && (rob.size() < D) && !m_clear;
      c0  = rdy && !m_clear && (rob.size() > 0) && rob[0].ready;
      c1  = c0 && (rob.size() > 1) && rob[1].ready && (rob[0].typ == 0) && (rob[1].typ == 0);
      ecv = '0; erd = '0; eval = '0; eid = '0;
      for (int s = 0; s < 2; s++) begin
         fire = (s == 0) ? c0 : c1;
         if (fire && (rob[s].typ == 0) && (rob[s].rd != 0)) begin
            ecv[s]          = 1'b1;
            erd[s*5 +: 5]   = 5'(rob[s].rd);
            eval[s*32 +: 32] = rob[s].value;
            eid[s*3 +: 3]   = 3'(rob[s].id);
         end
      end
      check_eq("commit_valid", o_commit_valid, 64'(ecv));
      check_eq("commit_rd", o_commit_rd, 64'(erd));
      check_eq("commit_value", o_commit_value, eval);
      check_eq("commit_id", o_commit_id, 64'(eid));
      check_eq("store_commit", o_store_commit, 64'(c0 && rob[0].typ == 2));
      check_eq("store_id", o_store_commit_id, (c0 && rob[0].typ == 2) ? 64'(rob[0].id) : 64'd0);
      check_eq("set_dep_valid", o_set_dep_valid, 64'(acc && atype == 0 && ard != 0));
      check_eq("set_dep_id", o_set_dep_id, (acc && atype == 0 && ard != 0) ? 64'(m_tail) : 64'd0);
      exp_query(int'(q0), acc, qr, qv);
      check_eq("query_ready0", o_query_ready0, 64'(qr));
      check_eq("query_value0", o_query_value0, 64'(qv));
      exp_query(int'(q1), acc, qr, qv);
      check_eq("query_ready1", o_query_ready1, 64'(qr));
      check_eq("query_value1", o_query_value1, 64'(qv));
      mis = c0 && (rob[0].typ == 1) && (rob[0].value[0] == 1'b0);
      @(posedge clk);
      if (rst) begin
         reset_model();
      end else if (rdy) begin
         if (m_clear) begin
            rob.delete(); m_head = 0; m_tail = 0; m_clear = 0;
         end else begin
            if (mis) begin
               m_clear = 1; m_next_pc = rob[0].jump;
            end
            if (wb0v) begin
               k = find_id(int'(wb0id));
               if (k >= 0) begin e = rob[k]; e.value = wb0val; e.ready = 1; rob[k] = e; end
            end
            if (wb1v) begin
               k = find_id(int'(wb1id));
               if (k >= 0) begin e = rob[k]; e.value = wb1val; e.ready = 1; rob[k] = e; end
            end
            n = int'(c0) + int'(c1);
            for (int s = 0; s < n; s++) void'(rob.pop_front());
            m_head = (m_head + n) % D;
            if (acc) begin
               e.id = m_tail; e.ready = aready; e.typ = int'(atype); e.rd = int'(ard);
               e.value = avalue; e.jump = ajump;
               rob.push_back(e);
               m_tail = (m_tail + 1) % D;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      reset_model();
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      do_reset();
      #1;
      check_eq("rst_empty", o_empty, 1);
      check_eq("rst_count", o_count, 0);
      check_eq("rst_clear", o_clear, 0);

      // Fill, overflow attempt, then dual commit.
      for (int i = 0; i < 8; i++) begin idle(); alloc(0, i + 1, 0, 0, 0); cycle(); end
      idle(); alloc(0, 9, 0, 0, 0); cycle();
      idle(); #1;
      check_eq("fill_full", o_full, 1);
      check_eq("fill_count", o_count, 8);
      check_eq("fill_tail", o_tail, 0);
      wb0v = 1; wb0id = 0; wb0val = 32'hA; wb1v = 1; wb1id = 1; wb1val = 32'hB;
      cycle();
      idle(); #1;
      check_eq("dual_valid", o_commit_valid, 2'b11);
      check_eq("dual_value", o_commit_value, {32'hB, 32'hA});
      cycle();
      check_eq("dual_count", o_count, 6);

      // Mispredicted branch.
      do_reset();
      alloc(1, 0, 1, 32'h0, 32'h100); cycle();
      idle(); cycle();
      check_eq("mp_clear", o_clear, 1);
      check_eq("mp_pc", o_next_pc, 32'h100);
      cycle();
      check_eq("mp_empty", o_empty, 1);
      check_eq("mp_head", o_head, 0);
      check_eq("mp_tail", o_tail, 0);

      // Store retires alone.
      do_reset();
      alloc(2, 0, 0, 0, 0); cycle();
      idle(); alloc(0, 5, 1, 32'h77, 0); cycle();
      idle(); wb0v = 1; wb0id = 0; wb0val = 0; cycle();
      idle(); #1;
      check_eq("st_commit", o_store_commit, 1);
      check_eq("st_id", o_store_commit_id, 0);
      check_eq("st_alone", o_commit_valid, 0);
      cycle();
      check_eq("st_next_r", o_commit_valid, 2'b01);
      check_eq("st_next_val", o_commit_value[31:0], 32'h77);
      cycle();

      // Forwarding and same-id writeback collision.
      do_reset();
      for (int i = 0; i < 4; i++) begin idle(); alloc(0, i + 1, 0, 0, 0); cycle(); end
      idle(); wb0v = 1; wb0id = 3; wb0val = 32'h55; q0 = 3; #1;
      check_eq("fwd_ready", o_query_ready0, 1);
      check_eq("fwd_value", o_query_value0, 32'h55);
      cycle();
      idle(); wb0v = 1; wb0id = 2; wb0val = 32'h11; wb1v = 1; wb1id = 2; wb1val = 32'h22;
      cycle();
      idle(); q1 = 2; #1;
      check_eq("coll_ready", o_query_ready1, 1);
      check_eq("coll_value", o_query_value1, 32'h22);
      cycle();

      // Wrap-around with a three-cycle stall.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         if (i == 10) begin
            for (int j = 0; j < 3; j++) begin
               idle(); rdy = 0; alloc(0, 30, 1, 32'hDEAD, 0); #1;
               check_eq("stall_cv", o_commit_valid, 0);
               check_eq("stall_dep", o_set_dep_valid, 0);
               cycle();
            end
         end
         idle(); alloc(0, i + 1, 1, 32'(i), 0); cycle();
      end
      idle(); cycle();
      check_eq("wrap_head", o_head, 4);
      check_eq("wrap_tail", o_tail, 4);
      check_eq("wrap_empty", o_empty, 1);

      // Reset overrides a pending flush.
      do_reset();
      alloc(1, 0, 1, 32'h0, 32'h200); cycle();
      idle(); cycle();
      rst = 1; cycle();
      rst = 0; #1;
      check_eq("rstclr_clear", o_clear, 0);
      check_eq("rstclr_pc", o_next_pc, 0);
      check_eq("rstclr_empty", o_empty, 1);

      // Random traffic.
      for (int t = 0; t < 3000; t++) begin
         int r;
         idle();
         rst = ($urandom_range(0, 499) == 0);
         rdy = ($urandom_range(0, 9) != 0);
         av  = ($urandom_range(0, 9) < 6);
         r   = $urandom_range(0, 9);
         atype  = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
         ard    = 5'($urandom_range(0, 31));
         avalue = $urandom;
         apc    = $urandom;
         ajump  = $urandom;
         aready = ($urandom_range(0, 9) < 4);
         wb0v   = $urandom_range(0, 1);
         wb1v   = $urandom_range(0, 1);
         wb0id  = (rob.size() > 0 && $urandom_range(0, 4) != 0) ?
                  3'(rob[$urandom_range(0, rob.size() - 1)].id) : 3'($urandom_range(0, 7));
         wb1id  = (rob.size() > 0 && $urandom_range(0, 4) != 0) ?
                  3'(rob[$urandom_range(0, rob.size() - 1)].id) : 3'($urandom_range(0, 7));
         wb0val = $urandom;
         wb1val = $urandom;
         q0     = 3'($urandom_range(0, 7));
         q1     = 3'($urandom_range(0, 7));
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
